// File: rtl/upsampler_frame_ctrl.sv
// Frame sequencer for the 2x upsampler: holds it in reset between frames, waits for the source
// FIFO to prime, strobes valid over one raster, and flags FIFO underflow.
module upsampler_frame_ctrl #(
   parameter int unsigned FILL_THRESH = 400,
   parameter int unsigned COL_LAST    = 840,
   parameter int unsigned ROW_LAST    = 640,
   parameter int unsigned CNT_W       = 11
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             enable_i,
   input  logic             frame_start_i,
   input  logic [CNT_W-1:0] fifo_count_i,
   input  logic             fifo_empty_i,
   input  logic             up_fifo_read_i,
   input  logic [9:0]       up_rowcount_i,
   input  logic [9:0]       up_colcount_i,
   output logic             up_reset_o,
   output logic             up_valid_o,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic             underflow_o,
   output logic [15:0]      frame_cnt_o,
   output logic [17:0]      read_cnt_o
);

   typedef enum logic [2:0] {StIdle, StPrime, StFill, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic        up_reset_q, up_valid_q, busy_q, frame_done_q, underflow_q;
   logic [15:0] frame_cnt_q;
   logic [17:0] read_cnt_q;
   logic        end_of_raster, fill_ok;

   assign end_of_raster = (up_rowcount_i == 10'(ROW_LAST)) && (up_colcount_i == 10'(COL_LAST));
   assign fill_ok       = (fifo_count_i >= CNT_W'(FILL_THRESH));

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (enable_i || frame_start_i) state_d = StPrime;
         StPrime: state_d = StFill;
         StFill:  if (fill_ok) state_d = StRun;
         StRun:   if (end_of_raster) state_d = StDone;
         StDone:  state_d = enable_i ? StPrime : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q      <= StIdle;
         up_reset_q   <= 1'b1;
         up_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underflow_q  <= 1'b0;
         frame_cnt_q  <= 16'd0;
         read_cnt_q   <= 18'd0;
      end else begin
         state_q      <= state_d;
         up_reset_q   <= (state_d == StIdle) || (state_d == StPrime);
         up_valid_q   <= (state_d == StRun);
         busy_q       <= (state_d != StIdle);
         frame_done_q <= (state_d == StDone);
         if (state_q == StRun && end_of_raster) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (state_d == StPrime) begin
            underflow_q <= 1'b0;
            read_cnt_q  <= 18'd0;
         end else if (state_q == StRun && up_fifo_read_i) begin
            if (read_cnt_q != '1) read_cnt_q <= read_cnt_q + 18'd1;
            if (fifo_empty_i) underflow_q <= 1'b1;
         end
      end
   end

   assign up_reset_o   = up_reset_q;
   assign up_valid_o   = up_valid_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;
   assign underflow_o  = underflow_q;
   assign frame_cnt_o  = frame_cnt_q;
   assign read_cnt_o   = read_cnt_q;

endmodule

// File: tb/tb_upsampler_frame_ctrl.sv
// Scoreboard bench for upsampler_frame_ctrl: a small upsampler counter model walks a shortened
// raster (starting near the last rows) and a monitor checks each frame_done against the queue.
module tb_upsampler_frame_ctrl;

   localparam int unsigned ColLast = 840;
   localparam int unsigned RowLast = 640;

   typedef struct {
      logic [15:0] fc;
      logic [17:0] rc;
      logic        uf;
      int          run;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        frame_start = 1'b0;
   logic [10:0] fifo_count = 11'd400;
   logic        fifo_empty;
   logic        up_fifo_read;
   logic [9:0]  col = '0;
   logic [9:0]  row = '0;
   logic        up_reset, up_valid, busy, frame_done, underflow;
   logic [15:0] frame_cnt;
   logic [17:0] read_cnt;

   int   row_start = 640;
   logic uf_mode = 1'b0;
   int   tb_reads = 0;
   int   run_cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_done = 0;
   exp_t sb[$];

   upsampler_frame_ctrl dut (
      .clock_i        (clock),
      .reset_ni       (reset_n),
      .enable_i       (enable),
      .frame_start_i  (frame_start),
      .fifo_count_i   (fifo_count),
      .fifo_empty_i   (fifo_empty),
      .up_fifo_read_i (up_fifo_read),
      .up_rowcount_i  (row),
      .up_colcount_i  (col),
      .up_reset_o     (up_reset),
      .up_valid_o     (up_valid),
      .busy_o         (busy),
      .frame_done_o   (frame_done),
      .underflow_o    (underflow),
      .frame_cnt_o    (frame_cnt),
      .read_cnt_o     (read_cnt)
   );

   always #5 clock = ~clock;

   // Upsampler model: reads one source word per even column on even rows.
   assign up_fifo_read = up_valid && !col[0] && !row[0];
   assign fifo_empty   = uf_mode && (tb_reads == 0);

   always @(posedge clock) begin
      if (up_reset === 1'b1) begin
         col      <= '0;
         row      <= 10'(row_start);
         tb_reads <= 0;
         run_cyc  <= 0;
      end else if (up_valid === 1'b1) begin
         run_cyc <= run_cyc + 1;
         if (up_fifo_read) tb_reads <= tb_reads + 1;
         if (col == 10'(ColLast)) begin
            col <= '0;
            row <= (row == 10'(RowLast)) ? 10'd0 : row + 10'd1;
         end else begin
            col <= col + 10'd1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every frame_done pulse is matched against the oldest expected frame.
   always @(negedge clock) begin
      if (reset_n && frame_done === 1'b1) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected frame_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
            chk("read_cnt", 32'(read_cnt), 32'(e.rc));
            chk("underflow", 32'(underflow), 32'(e.uf));
            chk("run length", 32'(run_cyc), 32'(e.run));
            chk("valid low in done", 32'(up_valid), 32'd0);
         end
      end
   end

   task automatic push(input int fc, input int rc, input logic uf, input int run);
      exp_t e;
      e.fc = 16'(fc); e.rc = 18'(rc); e.uf = uf; e.run = run;
      sb.push_back(e);
   endtask

   task automatic wait_done(input int budget, input string tag);
      int  start = n_done;
      logic seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (n_done > start) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, " done seen"}, 32'(seen), 32'd1);
   endtask

   task automatic wait_valid(input int budget, input string tag);
      logic seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (up_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, " valid seen"}, 32'(seen), 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge clock) frame_start = 1'b1;
      @(negedge clock) frame_start = 1'b0;
   endtask

   initial begin
      int bad;
      logic seen;
      repeat (3) @(negedge clock);
      chk("rst up_reset", 32'(up_reset), 32'd1);
      chk("rst up_valid", 32'(up_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst frame_done", 32'(frame_done), 32'd0);
      chk("rst underflow", 32'(underflow), 32'd0);
      chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst read_cnt", 32'(read_cnt), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Single frame over two rows: 2*841 RUN cycles, 421 reads on row 640.
      row_start = 639;
      push(1, 421, 1'b0, 1682);
      pulse_start();
      chk("prime busy", 32'(busy), 32'd1);
      chk("prime up_reset", 32'(up_reset), 32'd1);
      chk("prime up_valid", 32'(up_valid), 32'd0);
      @(negedge clock);
      chk("fill up_reset", 32'(up_reset), 32'd0);
      chk("fill up_valid", 32'(up_valid), 32'd0);
      @(negedge clock);
      chk("run up_valid", 32'(up_valid), 32'd1);
      wait_done(3000, "t1");
      repeat (2) @(negedge clock);
      chk("t1 idle busy", 32'(busy), 32'd0);
      chk("t1 idle up_reset", 32'(up_reset), 32'd1);

      // FIFO one word short of the threshold holds the sequencer in FILL.
      row_start = 640;
      fifo_count = 11'd399;
      push(2, 421, 1'b0, 841);
      pulse_start();
      bad = 0;
      repeat (50) begin
         @(negedge clock);
         if (up_valid !== 1'b0 || busy !== 1'b1) bad++;
      end
      chk("fill hold", 32'(bad), 32'd0);
      fifo_count = 11'd400;
      chk("valid before threshold edge", 32'(up_valid), 32'd0);
      @(negedge clock);
      chk("valid after threshold edge", 32'(up_valid), 32'd1);
      wait_done(2000, "t2");
      repeat (2) @(negedge clock);

      // Back-to-back frames; enable drops mid-way through the third.
      push(3, 421, 1'b0, 841);
      push(4, 421, 1'b0, 841);
      push(5, 421, 1'b0, 841);
      @(negedge clock) enable = 1'b1;
      wait_done(2000, "t3a");
      wait_done(2000, "t3b");
      wait_valid(20, "t3c");
      enable = 1'b0;
      wait_done(2000, "t3c");
      repeat (3) @(negedge clock);
      chk("t3 idle busy", 32'(busy), 32'd0);

      // Empty FIFO on the first read: sticky underflow, cleared on the next PRIME.
      uf_mode = 1'b1;
      push(6, 421, 1'b1, 841);
      pulse_start();
      wait_done(2000, "t4a");
      repeat (2) @(negedge clock);
      chk("underflow sticky", 32'(underflow), 32'd1);
      uf_mode = 1'b0;
      push(7, 421, 1'b0, 841);
      @(negedge clock) frame_start = 1'b1;
      @(negedge clock) frame_start = 1'b0;
      chk("underflow cleared in prime", 32'(underflow), 32'd0);
      chk("read_cnt cleared in prime", 32'(read_cnt), 32'd0);
      wait_done(2000, "t4b");
      repeat (2) @(negedge clock);

      // Reset mid-RUN at row 300.
      row_start = 299;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (row == 10'd300 && up_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("t5 reached row 300", 32'(seen), 32'd1);
      reset_n = 1'b0;
      @(negedge clock);
      chk("t5 up_valid", 32'(up_valid), 32'd0);
      chk("t5 up_reset", 32'(up_reset), 32'd1);
      chk("t5 frame_cnt", 32'(frame_cnt), 32'd0);
      chk("t5 busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // frame_start during RUN is not queued.
      row_start = 640;
      push(1, 421, 1'b0, 841);
      pulse_start();
      wait_valid(20, "t6");
      repeat (10) @(negedge clock);
      frame_start = 1'b1;
      @(negedge clock) frame_start = 1'b0;
      wait_done(2000, "t6");
      repeat (900) @(negedge clock);
      chk("t6 busy", 32'(busy), 32'd0);
      chk("t6 frame_cnt", 32'(frame_cnt), 32'd1);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
